tx_car_map: RTL

TX_CAR_MAP -- requirements
Module: tx_car_map

---
 rtl/tx_car_map_pkg.sv | 30 +++
 rtl/tx_car_map_mem.sv | 21 ++
 rtl/tx_car_map.sv | 129 ++++++++++++
 3 files changed

// File: rtl/tx_car_map_pkg.sv
// Shared carrier-map constants, FSM encoding and helpers for the TX and RX carrier buffers.
package tx_car_map_pkg;

  localparam int unsigned CAR_NUM   = 256;
  localparam int unsigned DAT_NUM   = 200;
  localparam int unsigned NULL_LO   = 100;
  localparam int unsigned NULL_HI   = 154;
  localparam int unsigned NULL_LAST = 255;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = $clog2(CAR_NUM);
  localparam int unsigned PTR_W  = $clog2(DAT_NUM);
  localparam int unsigned OCC_W  = $clog2(DAT_NUM + 1);

  typedef enum logic [0:0] {
    ST_WAIT = 1'b0,
    ST_SEND = 1'b1
  } car_state_e;

  // Data carriers are everything outside the centre null band and the last index.
  function automatic logic is_data_car(input logic [IDX_W-1:0] idx);
    return (idx < IDX_W'(NULL_LO)) ||
           ((idx > IDX_W'(NULL_HI)) && (idx != IDX_W'(NULL_LAST)));
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DAT_NUM - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

endpackage

// File: rtl/tx_car_map_mem.sv
// 200 x 32 sample store: synchronous write, asynchronous read.
module tx_car_map_mem
  import tx_car_map_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DAT_NUM];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tx_car_map.sv
// TX carrier mapper: buffers data carriers and emits 256-carrier IFFT-order symbols with null carriers.
// Optional TX_CAR_MAP_SYMCNT_EN adds a 16-bit emitted-symbol counter output sym_cnt.
module tx_car_map
  import tx_car_map_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              din_val,
  output logic              din_rdy,
  output logic [DATA_W-1:0] dout,
  output logic              dout_val,
  input  logic              dout_rdy,
  output logic [IDX_W-1:0]  car_idx,
  output logic              sym_last
`ifdef TX_CAR_MAP_SYMCNT_EN
  ,
  output logic [15:0]       sym_cnt
`endif
);

  car_state_e         r_state;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [OCC_W-1:0]   r_occ;
  logic [IDX_W-1:0]   r_car_idx;
  logic               r_dout_val;
  logic               r_sym_last;
  logic               r_din_rdy;

  logic               w_wr;
  logic               w_we;
  logic               w_hs;
  logic               w_is_data;
  logic               w_rd;
  logic [OCC_W-1:0]   w_occ_nxt;
  logic [DATA_W-1:0]  w_mem_rdata;

  assign w_wr      = din_val & r_din_rdy;
  assign w_we      = w_wr & ~start & ~rst;
  assign w_hs      = r_dout_val & dout_rdy;
  assign w_is_data = is_data_car(r_car_idx);
  assign w_rd      = w_hs & w_is_data;

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_wr && !w_rd)      w_occ_nxt = r_occ + OCC_W'(1);
    else if (!w_wr && w_rd) w_occ_nxt = r_occ - OCC_W'(1);
  end

  tx_car_map_mem u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  // Pointers, occupancy and the WAIT/SEND emitter; start clears everything except memory.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_state    <= ST_WAIT;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_car_idx  <= '0;
      r_dout_val <= 1'b0;
      r_sym_last <= 1'b0;
      r_din_rdy  <= 1'b1;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_occ     <= w_occ_nxt;
      r_din_rdy <= (w_occ_nxt < OCC_W'(DAT_NUM));

      case (r_state)
        ST_WAIT: begin
          if (r_occ == OCC_W'(DAT_NUM)) begin
            r_state    <= ST_SEND;
            r_dout_val <= 1'b1;
            r_car_idx  <= '0;
            r_sym_last <= 1'b0;
          end
        end
        ST_SEND: begin
          if (w_hs) begin
            if (r_car_idx == IDX_W'(NULL_LAST)) begin
              r_car_idx  <= '0;
              r_sym_last <= 1'b0;
              // Continue back-to-back only if the next symbol is already complete.
              if (w_occ_nxt != OCC_W'(DAT_NUM)) begin
                r_state    <= ST_WAIT;
                r_dout_val <= 1'b0;
              end
            end else begin
              r_car_idx  <= r_car_idx + IDX_W'(1);
              r_sym_last <= (r_car_idx == IDX_W'(NULL_LAST - 1));
            end
          end
        end
        default: begin
          r_state    <= ST_WAIT;
          r_dout_val <= 1'b0;
          r_sym_last <= 1'b0;
        end
      endcase
    end
  end

`ifdef TX_CAR_MAP_SYMCNT_EN
  logic [15:0] r_sym_cnt;

  always_ff @(posedge clk) begin
    if (rst || start)           r_sym_cnt <= '0;
    else if (w_hs && r_sym_last) r_sym_cnt <= r_sym_cnt + 16'(1);
  end

  assign sym_cnt = r_sym_cnt;
`endif

  assign din_rdy  = r_din_rdy;
  assign dout_val = r_dout_val;
  assign car_idx  = r_car_idx;
  assign sym_last = r_sym_last;
  assign dout     = (r_dout_val && w_is_data) ? w_mem_rdata : '0;

endmodule
